// File: rtl/clk_div_pkg.sv
// Shared types, reset constants and config sanitising for the clk_div_gen divider family.
package clk_div_pkg;

  localparam int unsigned MIN_PERIOD = 2;
  localparam int unsigned RST_PERIOD = 2;
  localparam int unsigned RST_HIGH   = 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStop
  } ch_state_e;

  typedef struct packed {
    logic [31:0] period;
    logic [31:0] high;
  } div_cfg_t;

  // Clamp a requested config so the output always toggles: period >= 2, 1 <= high < period.
  function automatic div_cfg_t sanitize_cfg(input logic [31:0] period, input logic [31:0] high);
    div_cfg_t c;
    c.period = (period < MIN_PERIOD) ? MIN_PERIOD : period;
    c.high   = (high == 32'd0) ? 32'd1 : high;
    if (c.high >= c.period) c.high = c.period - 32'd1;
    return c;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: shadow/active config, period counter and IDLE/RUN/STOP sequencing.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ch_en,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic             phase_sync,
  output logic             clk_out,
  output logic             tick,
  output logic             cfg_pending
);

  ch_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] act_period, act_high;
  logic [CNT_W-1:0] sh_period, sh_high;
  logic             wrap;
  logic             sync;
  logic             apply;
  div_cfg_t         load_cfg;
  logic             unused_load_cfg;

  // Inputs are zero-extended, so the sanitised result always fits back into CNT_W bits.
  assign load_cfg        = sanitize_cfg(32'(cfg_period), 32'(cfg_high));
  assign unused_load_cfg = ^load_cfg;

  assign cnt_inc = cnt + CNT_W'(1);
  assign wrap    = (state != StIdle) && (cnt == act_period - CNT_W'(1));
  assign sync    = (state != StIdle) && phase_sync;
  // A shadow config only lands at a period boundary (or immediately when idle).
  assign apply   = cfg_pending && ((state == StIdle) || wrap || sync);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      cnt         <= '0;
      clk_out     <= 1'b0;
      tick        <= 1'b0;
      cfg_pending <= 1'b0;
      act_period  <= CNT_W'(RST_PERIOD);
      act_high    <= CNT_W'(RST_HIGH);
      sh_period   <= CNT_W'(RST_PERIOD);
      sh_high     <= CNT_W'(RST_HIGH);
    end else begin
      if (apply) begin
        act_period <= sh_period;
        act_high   <= sh_high;
      end
      // A load coinciding with an apply lands in the shadow and waits for the next boundary.
      if (cfg_load) begin
        sh_period   <= CNT_W'(load_cfg.period);
        sh_high     <= CNT_W'(load_cfg.high);
        cfg_pending <= 1'b1;
      end else if (apply) begin
        cfg_pending <= 1'b0;
      end

      unique case (state)
        StIdle: begin
          cnt <= '0;
          if (ch_en) begin
            state   <= StRun;
            clk_out <= 1'b1;
            tick    <= 1'b1;
          end else begin
            clk_out <= 1'b0;
            tick    <= 1'b0;
          end
        end
        StRun, StStop: begin
          if (sync || (wrap && ch_en)) begin
            state   <= ch_en ? StRun : StStop;
            cnt     <= '0;
            clk_out <= 1'b1;
            tick    <= 1'b1;
          end else if (wrap) begin
            state   <= StIdle;
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
          end else begin
            state   <= ch_en ? StRun : StStop;
            cnt     <= cnt_inc;
            clk_out <= (cnt_inc < act_high);
            tick    <= 1'b0;
          end
        end
        default: begin
          state   <= StIdle;
          cnt     <= '0;
          clk_out <= 1'b0;
          tick    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider with glitch-free config apply at period boundaries.
// Define CLK_DIV_PHASE_ALIGN_EN to add the phase_sync input that realigns all running channels.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH-1:0]       cfg_load,
  input  logic [NUM_CH*CNT_W-1:0] cfg_period,
  input  logic [NUM_CH*CNT_W-1:0] cfg_high,
`ifdef CLK_DIV_PHASE_ALIGN_EN
  input  logic                    phase_sync,
`endif
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       cfg_pending
);

  logic sync_pulse;

`ifdef CLK_DIV_PHASE_ALIGN_EN
  assign sync_pulse = phase_sync;
`else
  assign sync_pulse = 1'b0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .ch_en      (ch_en[i]),
      .cfg_load   (cfg_load[i]),
      .cfg_period (cfg_period[i*CNT_W +: CNT_W]),
      .cfg_high   (cfg_high[i*CNT_W +: CNT_W]),
      .phase_sync (sync_pulse),
      .clk_out    (clk_out[i]),
      .tick       (tick[i]),
      .cfg_pending(cfg_pending[i])
    );
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Randomised bench for clk_div_gen checked every cycle against a period-position reference model.
module tb_clk_div_gen;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;

  logic                    clk;
  logic                    rst;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH-1:0]       cfg_load;
  logic [NUM_CH*CNT_W-1:0] cfg_period;
  logic [NUM_CH*CNT_W-1:0] cfg_high;
  logic                    phase_sync;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       cfg_pending;

  int checks   = 0;
  int failures = 0;

  clk_div_gen #(
    .NUM_CH(NUM_CH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ch_en      (ch_en),
    .cfg_load   (cfg_load),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
`ifdef CLK_DIV_PHASE_ALIGN_EN
    .phase_sync (phase_sync),
`endif
    .clk_out    (clk_out),
    .tick       (tick),
    .cfg_pending(cfg_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each channel is either off or at position pos inside a period.
  int act_p[NUM_CH], act_h[NUM_CH], sh_p[NUM_CH], sh_h[NUM_CH], pos[NUM_CH];
  bit on[NUM_CH], pend[NUM_CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at %0t: observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  function automatic void sanitize(input int p, input int h, output int op, output int oh);
    op = (p < 2) ? 2 : p;
    oh = (h == 0) ? 1 : h;
    if (oh >= op) oh = op - 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      act_p[i] = 2; act_h[i] = 1; sh_p[i] = 2; sh_h[i] = 1;
      pos[i] = 0; on[i] = 0; pend[i] = 0;
    end
  endtask

  task automatic model_update();
    int lp, lh;
    bit boundary, sync;
    if (rst) begin
      model_reset();
      return;
    end
`ifdef CLK_DIV_PHASE_ALIGN_EN
    sync = phase_sync;
`else
    sync = 0;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      sanitize(int'(cfg_period[i*CNT_W +: CNT_W]), int'(cfg_high[i*CNT_W +: CNT_W]), lp, lh);
      boundary = !on[i] || (pos[i] == act_p[i] - 1) || sync;
      if (boundary && pend[i]) begin
        act_p[i] = sh_p[i]; act_h[i] = sh_h[i]; pend[i] = 0;
      end
      if (cfg_load[i]) begin
        sh_p[i] = lp; sh_h[i] = lh; pend[i] = 1;
      end
      if (!on[i]) begin
        on[i] = ch_en[i]; pos[i] = 0;
      end else if (boundary) begin
        // Enable is only consulted at the end of a period; a sync restarts the period regardless.
        on[i] = ch_en[i] || sync; pos[i] = 0;
      end else begin
        pos[i]++;
      end
    end
  endtask

  task automatic step();
    logic [NUM_CH-1:0] e_clk, e_tick, e_pend;
    @(posedge clk);
    model_update();
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      e_clk[i]  = on[i] && (pos[i] < act_h[i]);
      e_tick[i] = on[i] && (pos[i] == 0);
      e_pend[i] = pend[i];
    end
    check("clk_out", 32'(clk_out), 32'(e_clk));
    check("tick", 32'(tick), 32'(e_tick));
    check("cfg_pending", 32'(cfg_pending), 32'(e_pend));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic load(input int ch, input int p, input int h);
    cfg_load = '0;
    cfg_load[ch] = 1'b1;
    cfg_period[ch*CNT_W +: CNT_W] = CNT_W'(p);
    cfg_high[ch*CNT_W +: CNT_W]   = CNT_W'(h);
    step();
    cfg_load = '0;
  endtask

  initial begin
    model_reset();
    rst = 1'b1; ch_en = '0; cfg_load = '0; cfg_period = '0; cfg_high = '0; phase_sync = 1'b0;
    step();
    check("rst_clk_out", 32'(clk_out), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    rst = 1'b0;
    run(2);

    // Default divide-by-2 on channel 0, then stop cleanly.
    ch_en[0] = 1'b1;
    step();
    check("first_tick", 32'(tick[0]), 32'd1);
    run(7);
    ch_en[0] = 1'b0;
    run(4);

    // Load 5/2 while idle, then run; mid-run load 8/4 waits for the boundary.
    load(0, 5, 2);
    step();
    ch_en[0] = 1'b1;
    run(12);
    load(0, 8, 4);
    check("pending_set", 32'(cfg_pending[0]), 32'd1);
    run(20);

    // Degenerate config sanitises to divide-by-2.
    load(0, 0, 9);
    run(12);

    // Stop part way through a 6/3 period, then restart.
    load(0, 6, 3);
    run(10);
    ch_en[0] = 1'b0;
    run(10);
    check("stopped_low", 32'(clk_out[0]), 32'd0);
    ch_en[0] = 1'b1;
    run(6);

    // Reset while both channels run.
    load(1, 7, 4);
    ch_en[1] = 1'b1;
    run(3);
    rst = 1'b1;
    step();
    check("midrst_clk_out", 32'(clk_out), 32'd0);
    rst = 1'b0;
    run(4);

`ifdef CLK_DIV_PHASE_ALIGN_EN
    load(0, 5, 2);
    load(1, 9, 3);
    run(7);
    phase_sync = 1'b1;
    step();
    phase_sync = 1'b0;
    check("sync_tick", 32'(tick), 32'(2'b11));
    run(10);
`endif

    // Random traffic.
    for (int k = 0; k < 6000; k++) begin
      rst = ($urandom_range(0, 399) == 0);
      phase_sync = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NUM_CH; i++) begin
        int p;
        if ($urandom_range(0, 29) == 0) ch_en[i] = ~ch_en[i];
        cfg_load[i] = ($urandom_range(0, 19) == 0);
        p = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
        cfg_period[i*CNT_W +: CNT_W] = CNT_W'(p);
        cfg_high[i*CNT_W +: CNT_W]   = CNT_W'($urandom_range(0, (p + 2 > 255) ? 255 : p + 2));
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
